// File: rtl/player_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : player_game_ctrl
// Purpose  : Top-level game controller running on the frame-rate clock.
//            Owns the game FSM (IDLE -> OPENING_SCREEN -> GAME_RUNNING ->
//            GAME_OVER), button-driven player motion with border clamping,
//            a saturating level counter and a start-button edge detector.
//            It consumes the asteroid engine's collision/exit flags and
//            produces the state and player position that the engine and
//            renderer consume.
//
// Ports    :
//   game_clk            in   1   frame-rate clock
//   rst                 in   1   asynchronous, active-low reset
//   btn                 in   5   [0]=start [1]=up [2]=down [3]=left [4]=right
//                                (already synchronised, level-sensitive)
//   collision_detected  in   1   registered collision flag from the engine
//   exit_reached        in   1   sticky exit flag from the engine
//   game_state          out  2   00 IDLE, 01 OPENING_SCREEN,
//                                10 GAME_RUNNING, 11 GAME_OVER
//   blkpos_x            out  11  player left edge
//   blkpos_y            out  11  player top edge
//   level               out  4   levels cleared, saturating at 15
//   lives               out  2   remaining lives
//
// Build option:
//   PLAYER_LIVES_EN  defined   -> three lives; a qualifying collision costs
//                                 one life and respawns the player until the
//                                 last life is lost.
//                    undefined -> lives reads constant 1; every qualifying
//                                 collision ends the game.
//
// Revision : 1.0  initial release
// ============================================================================
module player_game_ctrl #(
    parameter int SCREEN_WIDTH  = 1439,
    parameter int SCREEN_HEIGHT = 830,
    parameter int BORDER        = 50,
    parameter int BLK_SIZE      = 32,
    parameter int STEP          = 4,
    parameter int START_Y       = 790,
    parameter int OPEN_TICKS    = 120,
    parameter int GRACE_TICKS   = 2
) (
    input  logic        game_clk,
    input  logic        rst,
    input  logic [4:0]  btn,
    input  logic        collision_detected,
    input  logic        exit_reached,
    output logic [1:0]  game_state,
    output logic [10:0] blkpos_x,
    output logic [10:0] blkpos_y,
    output logic [3:0]  level,
    output logic [1:0]  lives
);

    // ------------------------------------------------------------------------
    // Derived constants. Position arithmetic is carried in 12 bits so that
    // x+STEP / y+STEP can never wrap before being compared to the limits.
    // ------------------------------------------------------------------------
    localparam int OPEN_W = (OPEN_TICKS > 1) ? $clog2(OPEN_TICKS) : 1;
    localparam int RUN_W  = (GRACE_TICKS > 0) ? $clog2(GRACE_TICKS + 1) : 1;

    localparam logic [11:0] SPAWN_X  = 12'((SCREEN_WIDTH - BLK_SIZE) / 2);
    localparam logic [11:0] SPAWN_Y  = 12'(START_Y);
    localparam logic [11:0] MIN_X    = 12'(BORDER);
    localparam logic [11:0] MAX_X    = 12'(SCREEN_WIDTH - BORDER - BLK_SIZE);
    localparam logic [11:0] MAX_Y    = 12'(SCREEN_HEIGHT - BLK_SIZE);
    localparam logic [11:0] STEP_12  = 12'(STEP);
    localparam logic [11:0] MIN_X_ST = 12'(BORDER + STEP);

    localparam logic [OPEN_W-1:0] OPEN_LAST = OPEN_W'(OPEN_TICKS - 1);
    localparam logic [RUN_W-1:0]  GRACE     = RUN_W'(GRACE_TICKS);

    typedef enum logic [1:0] {
        IDLE           = 2'b00,
        OPENING_SCREEN = 2'b01,
        GAME_RUNNING   = 2'b10,
        GAME_OVER      = 2'b11
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state and next-state values
    // ------------------------------------------------------------------------
    state_t              state,      state_nxt;
    logic [10:0]         pos_x,      pos_x_nxt;
    logic [10:0]         pos_y,      pos_y_nxt;
    logic [3:0]          level_r,    level_nxt;
    logic [OPEN_W-1:0]   open_cnt,   open_cnt_nxt;
    logic [RUN_W-1:0]    run_cnt,    run_cnt_nxt;
    logic                btn0_q;

`ifdef PLAYER_LIVES_EN
    logic [1:0]          lives_r,    lives_nxt;
`endif

    logic                start_p;
    logic                respawn;
    logic                hit;
    logic [11:0]         x_ext;
    logic [11:0]         y_ext;
    logic [11:0]         x_mv;
    logic [11:0]         y_mv;

    // Rising edge of the start button; btn0_q is sampled every cycle in
    // every state so that a held button never retriggers.
    assign start_p = btn[0] & ~btn0_q;

    // Collision only counts once the grace window after entering RUNNING
    // has elapsed; the engine may still report a stale hit from the
    // previous round during those first ticks.
    assign hit = collision_detected && (run_cnt >= GRACE);

    // ------------------------------------------------------------------------
    // Candidate motion for this tick. Opposite buttons on one axis cancel.
    // ------------------------------------------------------------------------
    always_comb begin
        x_ext = {1'b0, pos_x};
        y_ext = {1'b0, pos_y};
        x_mv  = x_ext;
        y_mv  = y_ext;

        if (btn[1] && !btn[2]) begin
            if (y_ext < STEP_12) begin
                y_mv = '0;
            end else begin
                y_mv = y_ext - STEP_12;
            end
        end else if (btn[2] && !btn[1]) begin
            if ((y_ext + STEP_12) > MAX_Y) begin
                y_mv = MAX_Y;
            end else begin
                y_mv = y_ext + STEP_12;
            end
        end

        if (btn[3] && !btn[4]) begin
            if (x_ext < MIN_X_ST) begin
                x_mv = MIN_X;
            end else begin
                x_mv = x_ext - STEP_12;
            end
        end else if (btn[4] && !btn[3]) begin
            if ((x_ext + STEP_12) > MAX_X) begin
                x_mv = MAX_X;
            end else begin
                x_mv = x_ext + STEP_12;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        pos_x_nxt    = pos_x;
        pos_y_nxt    = pos_y;
        level_nxt    = level_r;
        open_cnt_nxt = open_cnt;
        run_cnt_nxt  = run_cnt;
        respawn      = 1'b0;
`ifdef PLAYER_LIVES_EN
        lives_nxt    = lives_r;
`endif

        case (state)
            IDLE: begin
                if (start_p) begin
                    state_nxt    = OPENING_SCREEN;
                    open_cnt_nxt = '0;
                    respawn      = 1'b1;
                end
            end

            OPENING_SCREEN: begin
                // Player is pinned to the spawn point for the whole screen.
                // start_p is deliberately ignored: the engine re-rolls its
                // asteroid field on btn[0] by itself while this is shown.
                respawn = 1'b1;
                if (open_cnt == OPEN_LAST) begin
                    state_nxt   = GAME_RUNNING;
                    run_cnt_nxt = '0;
                end else begin
                    open_cnt_nxt = open_cnt + 1'b1;
                end
            end

            GAME_RUNNING: begin
                // Motion is taken on every RUNNING edge; a respawn below
                // overrides it when the round ends on this edge.
                pos_x_nxt = x_mv[10:0];
                pos_y_nxt = y_mv[10:0];

                if (run_cnt < GRACE) begin
                    run_cnt_nxt = run_cnt + 1'b1;
                end

                // Collision wins over an exit on the same tick.
                if (hit) begin
`ifdef PLAYER_LIVES_EN
                    if (lives_r > 2'd1) begin
                        lives_nxt    = lives_r - 2'd1;
                        state_nxt    = OPENING_SCREEN;
                        open_cnt_nxt = '0;
                        respawn      = 1'b1;
                    end else begin
                        lives_nxt = 2'd0;
                        state_nxt = GAME_OVER;
                    end
`else
                    state_nxt = GAME_OVER;
`endif
                end else if (exit_reached) begin
                    if (level_r != 4'hF) begin
                        level_nxt = level_r + 4'd1;
                    end
                    state_nxt    = OPENING_SCREEN;
                    open_cnt_nxt = '0;
                    respawn      = 1'b1;
                end
            end

            GAME_OVER: begin
                // Player stays frozen where it died until a new start press.
                if (start_p) begin
                    state_nxt    = OPENING_SCREEN;
                    level_nxt    = 4'd0;
                    open_cnt_nxt = '0;
                    respawn      = 1'b1;
`ifdef PLAYER_LIVES_EN
                    lives_nxt    = 2'd3;
`endif
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (respawn) begin
            pos_x_nxt = SPAWN_X[10:0];
            pos_y_nxt = SPAWN_Y[10:0];
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge game_clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pos_x    <= SPAWN_X[10:0];
            pos_y    <= SPAWN_Y[10:0];
            level_r  <= 4'd0;
            open_cnt <= '0;
            run_cnt  <= '0;
            btn0_q   <= 1'b0;
`ifdef PLAYER_LIVES_EN
            lives_r  <= 2'd3;
`endif
        end else begin
            state    <= state_nxt;
            pos_x    <= pos_x_nxt;
            pos_y    <= pos_y_nxt;
            level_r  <= level_nxt;
            open_cnt <= open_cnt_nxt;
            run_cnt  <= run_cnt_nxt;
            btn0_q   <= btn[0];
`ifdef PLAYER_LIVES_EN
            lives_r  <= lives_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign game_state = state;
    assign blkpos_x   = pos_x;
    assign blkpos_y   = pos_y;
    assign level      = level_r;
`ifdef PLAYER_LIVES_EN
    assign lives      = lives_r;
`else
    assign lives      = 2'd1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_player_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_game_ctrl
// Purpose  : Self-checking bench for player_game_ctrl. A behavioural model
//            of the game rules runs alongside the DUT; scenario tasks drive
//            directed and random stimulus and compare outputs inline.
//            Honours PLAYER_LIVES_EN the same way as the design.
// Revision : 1.0  initial release
// ============================================================================
module tb_player_game_ctrl;

    localparam int SPAWN_X    = 703;
    localparam int SPAWN_Y    = 790;
    localparam int MIN_X      = 50;
    localparam int MAX_X      = 1357;
    localparam int MAX_Y      = 798;
    localparam int STEP       = 4;
    localparam int OPEN_TICKS = 120;
    localparam int GRACE      = 2;

    localparam int ST_IDLE = 0;
    localparam int ST_OPEN = 1;
    localparam int ST_RUN  = 2;
    localparam int ST_OVER = 3;

`ifdef PLAYER_LIVES_EN
    localparam bit LIVES_EN = 1'b1;
`else
    localparam bit LIVES_EN = 1'b0;
`endif

    logic        game_clk = 1'b0;
    logic        rst      = 1'b0;
    logic [4:0]  btn      = 5'd0;
    logic        collision_detected = 1'b0;
    logic        exit_reached       = 1'b0;
    logic [1:0]  game_state;
    logic [10:0] blkpos_x;
    logic [10:0] blkpos_y;
    logic [3:0]  level;
    logic [1:0]  lives;

    player_game_ctrl dut (
        .game_clk           (game_clk),
        .rst                (rst),
        .btn                (btn),
        .collision_detected (collision_detected),
        .exit_reached       (exit_reached),
        .game_state         (game_state),
        .blkpos_x           (blkpos_x),
        .blkpos_y           (blkpos_y),
        .level              (level),
        .lives              (lives)
    );

    always #5 game_clk = ~game_clk;

    int total = 0;
    int bad   = 0;

    // ------------------------------------------------------------------------
    // Reference model: game rules expressed with plain integers
    // ------------------------------------------------------------------------
    int m_state, m_x, m_y, m_level, m_lives, m_open, m_run;
    bit m_btn0;

    task automatic model_reset();
        m_state = ST_IDLE;
        m_x     = SPAWN_X;
        m_y     = SPAWN_Y;
        m_level = 0;
        m_lives = LIVES_EN ? 3 : 1;
        m_open  = 0;
        m_run   = 0;
        m_btn0  = 1'b0;
    endtask

    task automatic model_step(input logic [4:0] b, input logic col, input logic ex);
        bit start_edge;
        bit respawn;
        start_edge = b[0] && !m_btn0;
        respawn    = 1'b0;
        m_btn0     = b[0];
        case (m_state)
            ST_IDLE: begin
                if (start_edge) begin
                    m_state = ST_OPEN; m_open = 0; respawn = 1'b1;
                end
            end
            ST_OPEN: begin
                // m_open = ticks already spent on the opening screen
                if (m_open + 1 == OPEN_TICKS) begin
                    m_state = ST_RUN; m_run = 0;
                end else begin
                    m_open++;
                end
            end
            ST_RUN: begin
                if (b[1] && !b[2]) m_y = (m_y < STEP) ? 0 : m_y - STEP;
                if (b[2] && !b[1]) m_y = (m_y + STEP > MAX_Y) ? MAX_Y : m_y + STEP;
                if (b[3] && !b[4]) m_x = (m_x - STEP < MIN_X) ? MIN_X : m_x - STEP;
                if (b[4] && !b[3]) m_x = (m_x + STEP > MAX_X) ? MAX_X : m_x + STEP;
                if (col && m_run >= GRACE) begin
                    if (LIVES_EN && m_lives > 1) begin
                        m_lives--; m_state = ST_OPEN; m_open = 0; respawn = 1'b1;
                    end else begin
                        if (LIVES_EN) m_lives = 0;
                        m_state = ST_OVER;
                    end
                end else if (ex) begin
                    m_level = (m_level >= 15) ? 15 : m_level + 1;
                    m_state = ST_OPEN; m_open = 0; respawn = 1'b1;
                end
                if (m_run < GRACE) m_run++;
            end
            default: begin
                if (start_edge) begin
                    m_state = ST_OPEN; m_level = 0; m_open = 0;
                    m_lives = LIVES_EN ? 3 : 1; respawn = 1'b1;
                end
            end
        endcase
        if (respawn) begin
            m_x = SPAWN_X; m_y = SPAWN_Y;
        end
    endtask

    function automatic logic [29:0] dut_vec();
        return {game_state, blkpos_x, blkpos_y, level, lives};
    endfunction

    function automatic logic [29:0] exp_vec();
        return {m_state[1:0], m_x[10:0], m_y[10:0], m_level[3:0], m_lives[1:0]};
    endfunction

    function automatic string diff_str();
        return $sformatf("got st=%0d x=%0d y=%0d lvl=%0d lives=%0d, want st=%0d x=%0d y=%0d lvl=%0d lives=%0d",
                         game_state, blkpos_x, blkpos_y, level, lives,
                         m_state, m_x, m_y, m_level, m_lives);
    endfunction

    // One clock: drive inputs, advance the model, sample #1 after the edge.
    task automatic tick(input logic [4:0] b, input logic col, input logic ex);
        btn                = b;
        collision_detected = col;
        exit_reached       = ex;
        model_step(b, col, ex);
        @(posedge game_clk);
        #1;
    endtask

    // Bring the game into a fresh RUNNING round (grace counter at zero).
    task automatic go_running();
        tick(5'd0, 1'b0, 1'b0);
        if (m_state == ST_RUN) tick(5'd0, 1'b0, 1'b1);
        else if (m_state == ST_IDLE || m_state == ST_OVER) tick(5'd1, 1'b0, 1'b0);
        for (int i = 0; i < 200 && m_state != ST_RUN; i++) tick(5'd0, 1'b0, 1'b0);
        total++;
        if (game_state !== 2'b10) begin
            bad++; $display("FAIL go_running: timed out, %s", diff_str());
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0; btn = 5'd0; collision_detected = 1'b0; exit_reached = 1'b0;
        model_reset();
        repeat (3) @(posedge game_clk);
        #1;
        total++;
        if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL reset_model: %s", diff_str());
        end
        total++;
        if (game_state !== 2'b00 || blkpos_x !== 11'd703 || blkpos_y !== 11'd790 ||
            level !== 4'd0 || lives !== (LIVES_EN ? 2'd3 : 2'd1)) begin
            bad++; $display("FAIL reset_values: %s", diff_str());
        end
        rst = 1'b1;
    endtask

    task automatic test_open_sequence();
        tick(5'd1, 1'b0, 1'b0);
        total++;
        if (game_state !== 2'b01) begin
            bad++; $display("FAIL open_enter: state got %0d want 1", game_state);
        end
        for (int i = 0; i < OPEN_TICKS - 1; i++) begin
            tick(5'd0, 1'b0, 1'b0);
            total++;
            if (dut_vec() !== exp_vec() || game_state !== 2'b01 ||
                blkpos_x !== 11'd703 || blkpos_y !== 11'd790) begin
                bad++; $display("FAIL open_hold[%0d]: %s", i, diff_str());
            end
        end
        tick(5'd0, 1'b0, 1'b0);
        total++;
        if (game_state !== 2'b10 || blkpos_x !== 11'd703 || blkpos_y !== 11'd790) begin
            bad++; $display("FAIL open_to_running: %s", diff_str());
        end
    endtask

    task automatic test_motion();
        for (int i = 0; i < 200; i++) begin
            tick(5'b01000, 1'b0, 1'b0);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL move_left[%0d]: %s", i, diff_str());
            end
        end
        total++;
        if (blkpos_x !== 11'd50) begin
            bad++; $display("FAIL left_clamp: x got %0d want 50", blkpos_x);
        end
        repeat (20) tick(5'b11000, 1'b0, 1'b0);
        total++;
        if (blkpos_x !== 11'd50) begin
            bad++; $display("FAIL left_right_cancel: x got %0d want 50", blkpos_x);
        end
        for (int i = 0; i < 400; i++) begin
            tick(5'b10000, 1'b0, 1'b0);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL move_right[%0d]: %s", i, diff_str());
            end
        end
        total++;
        if (blkpos_x !== 11'd1357) begin
            bad++; $display("FAIL right_clamp: x got %0d want 1357", blkpos_x);
        end
        repeat (197) tick(5'b00010, 1'b0, 1'b0);
        total++;
        if (blkpos_y !== 11'd2) begin
            bad++; $display("FAIL up_197: y got %0d want 2", blkpos_y);
        end
        tick(5'b00010, 1'b0, 1'b0);
        total++;
        if (blkpos_y !== 11'd0) begin
            bad++; $display("FAIL up_clamp: y got %0d want 0", blkpos_y);
        end
        repeat (199) tick(5'b00100, 1'b0, 1'b0);
        total++;
        if (blkpos_y !== 11'd796) begin
            bad++; $display("FAIL down_199: y got %0d want 796", blkpos_y);
        end
        repeat (6) tick(5'b00100, 1'b0, 1'b0);
        total++;
        if (blkpos_y !== 11'd798) begin
            bad++; $display("FAIL down_clamp: y got %0d want 798", blkpos_y);
        end
        repeat (10) tick(5'b00110, 1'b0, 1'b0);
        total++;
        if (dut_vec() !== exp_vec() || blkpos_y !== 11'd798) begin
            bad++; $display("FAIL up_down_cancel: %s", diff_str());
        end
    endtask

    task automatic test_exit_levels();
        for (int k = 0; k < 16; k++) begin
            int want_lvl;
            want_lvl = (k + 1 > 15) ? 15 : k + 1;
            repeat (3) tick(5'b01010, 1'b0, 1'b0);
            tick(5'd0, 1'b0, 1'b1);
            total++;
            if (dut_vec() !== exp_vec() || game_state !== 2'b01 || level !== want_lvl[3:0] ||
                blkpos_x !== 11'd703 || blkpos_y !== 11'd790) begin
                bad++; $display("FAIL exit[%0d]: want lvl=%0d, %s", k, want_lvl, diff_str());
            end
            repeat (OPEN_TICKS) tick(5'd0, 1'b0, 1'b0);
            total++;
            if (game_state !== 2'b10) begin
                bad++; $display("FAIL exit_reopen[%0d]: state got %0d want 2", k, game_state);
            end
        end
    endtask

    task automatic test_collision_grace();
        go_running();
        tick(5'b01000, 1'b1, 1'b0);
        total++;
        if (dut_vec() !== exp_vec() || game_state !== 2'b10) begin
            bad++; $display("FAIL grace_tick0: %s", diff_str());
        end
        tick(5'b01000, 1'b0, 1'b0);
        tick(5'd0, 1'b1, 1'b0);
        total++;
        if (dut_vec() !== exp_vec()) begin
            bad++; $display("FAIL grace_tick2: %s", diff_str());
        end
`ifdef PLAYER_LIVES_EN
        total++;
        if (game_state !== 2'b01 || lives !== 2'd2 || level !== 4'd15) begin
            bad++; $display("FAIL lives_first_hit: %s", diff_str());
        end
`else
        total++;
        if (game_state !== 2'b11 || blkpos_x !== 11'd695 || blkpos_y !== 11'd790) begin
            bad++; $display("FAIL hit_game_over: %s", diff_str());
        end
        repeat (5) tick(5'b01010, 1'b0, 1'b0);
        total++;
        if (blkpos_x !== 11'd695 || blkpos_y !== 11'd790 || game_state !== 2'b11) begin
            bad++; $display("FAIL over_frozen: %s", diff_str());
        end
        tick(5'd1, 1'b0, 1'b0);
        total++;
        if (game_state !== 2'b01 || level !== 4'd0 || blkpos_x !== 11'd703) begin
            bad++; $display("FAIL over_restart: %s", diff_str());
        end
`endif
    endtask

    task automatic test_exit_collision_priority();
        int lvl_before;
        go_running();
        tick(5'd0, 1'b0, 1'b1);
        go_running();
        tick(5'd0, 1'b0, 1'b0);
        tick(5'd0, 1'b0, 1'b0);
        lvl_before = m_level;
        tick(5'd0, 1'b1, 1'b1);
        total++;
        if (dut_vec() !== exp_vec() || level !== lvl_before[3:0] ||
            game_state !== (LIVES_EN ? 2'b01 : 2'b11)) begin
            bad++; $display("FAIL col_beats_exit: lvl want %0d, %s", lvl_before, diff_str());
        end
    endtask

    task automatic test_lives();
        for (int i = 0; i < 4 && m_state != ST_OVER; i++) begin
            go_running();
            tick(5'd0, 1'b0, 1'b0);
            tick(5'd0, 1'b0, 1'b0);
            tick(5'd0, 1'b1, 1'b0);
        end
        total++;
        if (game_state !== 2'b11 || lives !== (LIVES_EN ? 2'd0 : 2'd1)) begin
            bad++; $display("FAIL lives_reach_over: %s", diff_str());
        end
        tick(5'd0, 1'b0, 1'b0);
        tick(5'd1, 1'b0, 1'b0);
        total++;
        if (game_state !== 2'b01 || level !== 4'd0 || lives !== (LIVES_EN ? 2'd3 : 2'd1)) begin
            bad++; $display("FAIL lives_reload: %s", diff_str());
        end
`ifdef PLAYER_LIVES_EN
        for (int k = 0; k < 3; k++) begin
            go_running();
            tick(5'd0, 1'b0, 1'b0);
            tick(5'd0, 1'b0, 1'b0);
            tick(5'd0, 1'b1, 1'b0);
            total++;
            if (dut_vec() !== exp_vec() || lives !== 2'(2 - k) ||
                game_state !== ((k == 2) ? 2'b11 : 2'b01)) begin
                bad++; $display("FAIL lives_hit[%0d]: %s", k, diff_str());
            end
        end
`else
        go_running();
        tick(5'd0, 1'b0, 1'b0);
        tick(5'd0, 1'b0, 1'b0);
        tick(5'd0, 1'b1, 1'b0);
        total++;
        if (game_state !== 2'b11 || lives !== 2'd1) begin
            bad++; $display("FAIL single_life: %s", diff_str());
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] b;
            logic       c;
            logic       e;
            b = 5'($urandom);
            c = ($urandom_range(0, 39) == 0);
            e = ($urandom_range(0, 59) == 0);
            tick(b, c, e);
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++; $display("FAIL random[%0d]: %s", i, diff_str());
            end
        end
    endtask

    task automatic test_async_reset();
        go_running();
        repeat (5) tick(5'b10100, 1'b0, 1'b0);
        @(negedge game_clk);
        #2;
        rst = 1'b0; btn = 5'd0; collision_detected = 1'b0; exit_reached = 1'b0;
        model_reset();
        #1;
        total++;
        if (dut_vec() !== exp_vec() || game_state !== 2'b00 ||
            blkpos_x !== 11'd703 || blkpos_y !== 11'd790) begin
            bad++; $display("FAIL async_reset: %s", diff_str());
        end
        @(negedge game_clk);
        rst = 1'b1;
        tick(5'd1, 1'b0, 1'b0);
        total++;
        if (dut_vec() !== exp_vec() || game_state !== 2'b01) begin
            bad++; $display("FAIL after_reset_start: %s", diff_str());
        end
    endtask

    initial begin
        test_reset();
        test_open_sequence();
        test_motion();
        test_exit_levels();
        test_collision_grace();
        test_exit_collision_priority();
        test_lives();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
